frame_sync_rx: RTL
==================

// Module: frame_sync_rx
// PURPOSE
//   Receive end of the serial framed link: takes the recovered bit stream (one bit per bit_en strobe),
//   hunts for the sync byte, confirms frame alignment, then emits the payload as bytes with a 1-cycle valid.
//   Sits after bit recovery / demodulation and before the byte sink.
//   Flywheels through isolated sync errors, and drops lock after repeated misses.
// PARAMETERS
//   SYNC_WORD    8'h47  sync byte, transmitted MSB-first, once at the start of every frame
//   FRAME_BYTES  4      payload bytes after each sync byte (1..255); frame = (FRAME_BYTES+1)*8 bits
//   LOCK_CNT     2      consecutive sync matches, including the one found in HUNT, needed to declare lock (>=1)
//   LOSS_CNT     3      consecutive sync misses while locked that drop lock (>=1)
// PORTS
//   clk          in   1  system clock; all state updates on posedge
//   reset        in   1  asynchronous, active-low reset
//   bit_en       in   1  bit strobe; bit_in is valid only in cycles where it is 1; may be high every cycle
//   bit_in       in   1  serial data bit, MSB of each byte first
//   data_out     out  8  last completed payload byte; held until the next byte completes
//   data_valid   out  1  1-cycle pulse: data_out is new
//   frame_start  out  1  1-cycle pulse: sync byte matched while locked, or lock just acquired
//   locked       out  1  1 while in LOCK state
//   sync_err     out  1  1-cycle pulse: expected sync position held a non-sync byte while locked
// BEHAVIOUR
//   Reset: state=HUNT; shift reg, bit_cnt, byte_cnt, match_cnt, miss_cnt = 0; all outputs = 0.
//   Shift: on bit_en, sreg <= {sreg[6:0], bit_in}; sreg_nx is this new value; all comparisons use sreg_nx.
//   No state, counter or output changes in cycles where bit_en=0, except that the pulses deassert.
//   Frame position counters advance on bit_en only: bit_cnt 0..7, then byte_cnt 0..FRAME_BYTES.
//   byte_cnt==0 is the sync slot; both counters wrap to 0 after the last payload bit.
//   HUNT: evaluate every bit_en; if sreg_nx==SYNC_WORD -> clear counters, match_cnt=1.
//     If LOCK_CNT==1, go directly to LOCK and pulse frame_start; otherwise go to CHECK.
//   CHECK: count through the frame silently (no data_valid).
//     At the bit_en that completes the next sync slot: on match, match_cnt++;
//     when the incremented value == LOCK_CNT -> LOCK, pulse frame_start. On mismatch -> HUNT, match_cnt=0.
//   LOCK: locked=1. At each bit_en completing a payload byte (bit_cnt==7, byte_cnt>=1):
//     data_out <= sreg_nx, data_valid=1 on the next cycle.
//     At completion of the sync slot: on match, miss_cnt=0 and pulse frame_start.
//     On mismatch, pulse sync_err and miss_cnt++. If miss_cnt reaches LOSS_CNT -> HUNT (locked=0 next cycle).
//     Otherwise keep flywheeling, and still output the payload bytes that follow.
//   Latency: all pulses and data_out are registered; they appear 1 clk after the qualifying bit_en.
//   On HUNT re-entry: counters are cleared. The sync search restarts on the next bit_en.
//     Bits already in sreg are not rescanned, and sreg is not cleared.
//   Back-to-back bit_en: a full byte every 8 clks is sustained with no gaps.
//   Async reset mid-frame: immediate return to the reset state. A partial byte is discarded, never emitted.
//   A sync pattern inside the payload is ignored outside HUNT.
// STRUCTURE
//   Shared package/header comm_pkg: state encoding HUNT=2'd0, CHECK=2'd1, LOCK=2'd2;
//     default SYNC_WORD constant, shared with the frame transmitter.
//   Sub-module sync_shift8: 8-bit shift register with enable, posedge clk, async active-low reset to 0.
//   Top level: FSM, bit/byte counters, match/miss counters, output registers.
// TESTING  (SYNC_WORD=8'h47, FRAME_BYTES=4, LOCK_CNT=2, LOSS_CNT=3, bit_en every clk unless noted)
//   1 Send 13 random bits, then 3 frames 47 11 22 33 44.
//     -> locked rises after the 2nd sync byte; frame_start pulses at syncs 2 and 3.
//     -> Frame 3 data_valid x4 with data_out 11,22,33,44; no output from frame 1.
//   2 While locked, corrupt one sync byte (0x46).
//     -> exactly one sync_err pulse; locked stays 1; that frame's 4 payload bytes are still output.
//     -> The next good sync clears the miss count.
//   3 While locked, corrupt 3 consecutive sync bytes.
//     -> 3 sync_err pulses; locked falls 1 clk after the 3rd; relock needs 2 good syncs.
//   4 In HUNT, send payload containing 0x47 at a false offset, then a mismatched next sync slot.
//     -> CHECK goes back to HUNT; locked never rises.
//   5 Drive bit_en every 3rd clk with the same stream as scenario 1.
//     -> identical data_out sequence; data_valid is still a 1-clk pulse.
//   6 Assert reset mid-payload-byte while locked.
//     -> all outputs 0 immediately; no partial byte is emitted; the stream is re-acquired from HUNT afterwards.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared framing definitions for the serial link receiver and transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package comm_pkg;

    // Receiver alignment states
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } sync_state_t;

    // Default sync byte, sent MSB-first at the start of every frame
    localparam logic [7:0] SYNC_WORD_DEF = 8'h47;

endpackage

// File: rtl/sync_shift8.sv
// 8-bit MSB-first shift register that also presents the value it is about to load.
// Latency: q_nx is combinational from d; the register updates on the enabled clock edge.
// Backpressure: none; shifts on every cycle en is high.
module sync_shift8
    import comm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       d,
    output logic [7:0] q_nx
);

    logic [7:0] q;

    // Next register value: oldest bit falls off the top, new bit enters at the bottom
    always_comb begin
        q_nx = {q[6:0], d};
    end

    // Shift register, only moves on enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= q_nx;
        end
    end

endmodule

// File: rtl/frame_sync_rx.sv
// Frame aligner: hunts the sync byte, confirms alignment, then emits payload bytes with a 1-cycle valid.
// Latency: every output is registered and appears 1 clk after the bit_en that qualifies it.
// Backpressure: none; the byte sink must accept one byte per 8 bit_en strobes.
module frame_sync_rx
    import comm_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD   = SYNC_WORD_DEF,
    parameter int unsigned FRAME_BYTES = 4,
    parameter int unsigned LOCK_CNT    = 2,
    parameter int unsigned LOSS_CNT    = 3
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES);
    localparam logic [7:0] LOCK_TGT  = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TGT  = 8'(LOSS_CNT);

    sync_state_t state;
    sync_state_t state_nx;
    logic [7:0]  sreg_nx;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [7:0]  match_cnt;
    logic [7:0]  match_nx;
    logic [7:0]  miss_cnt;
    logic [7:0]  miss_nx;
    logic        sync_hit;
    logic        slot_done;
    logic        byte_done;
    logic        dv_nx;
    logic        fs_nx;
    logic        se_nx;

    sync_shift8 u_shift (
        .clk   (clk),
        .reset (reset),
        .en    (bit_en),
        .d     (bit_in),
        .q_nx  (sreg_nx)
    );

    // Frame-position decode: the current bit finishes the sync slot or a payload byte
    always_comb begin
        sync_hit  = (sreg_nx == SYNC_WORD);
        slot_done = (bit_cnt == 3'd7) && (byte_cnt == 8'd0);
        byte_done = (bit_cnt == 3'd7) && (byte_cnt != 8'd0);
    end

    // State register together with the lock-qualification and loss counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_nx;
            match_cnt <= match_nx;
            miss_cnt  <= miss_nx;
        end
    end

    // Next-state logic; nothing moves unless a bit arrives
    always_comb begin
        state_nx = state;
        match_nx = match_cnt;
        miss_nx  = miss_cnt;
        if (bit_en) begin
            case (state)
                HUNT: begin
                    if (sync_hit) begin
                        match_nx = 8'd1;
                        state_nx = (LOCK_TGT == 8'd1) ? LOCK : CHECK;
                    end
                end
                CHECK: begin
                    if (slot_done) begin
                        if (sync_hit) begin
                            match_nx = match_cnt + 8'd1;
                            if (match_nx == LOCK_TGT) begin
                                state_nx = LOCK;
                            end
                        end else begin
                            match_nx = '0;
                            state_nx = HUNT;
                        end
                    end
                end
                LOCK: begin
                    if (slot_done) begin
                        if (sync_hit) begin
                            miss_nx = '0;
                        end else begin
                            miss_nx = miss_cnt + 8'd1;
                            if (miss_nx == LOSS_TGT) begin
                                miss_nx  = '0;
                                match_nx = '0;
                                state_nx = HUNT;
                            end
                        end
                    end
                end
                default: begin
                    state_nx = HUNT;
                    match_nx = '0;
                    miss_nx  = '0;
                end
            endcase
        end
    end

    // FSM outputs: lock flag and the pulse values to register this cycle
    always_comb begin
        locked = (state == LOCK);
        dv_nx  = bit_en && (state == LOCK) && byte_done;
        se_nx  = bit_en && (state == LOCK) && slot_done && !sync_hit;
        fs_nx  = bit_en && (((state == LOCK) && slot_done && sync_hit) ||
                            ((state != LOCK) && (state_nx == LOCK)));
    end

    // Frame position counters; a HUNT hit means the sync byte just ended, so the
    // next bit is the first bit of payload byte 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (bit_en) begin
            if (state_nx == HUNT) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (state == HUNT) begin
                bit_cnt  <= '0;
                byte_cnt <= 8'd1;
            end else if (bit_cnt == 3'd7) begin
                bit_cnt  <= '0;
                byte_cnt <= (byte_cnt == LAST_BYTE) ? 8'd0 : byte_cnt + 8'd1;
            end else begin
                bit_cnt  <= bit_cnt + 3'd1;
            end
        end
    end

    // Registered outputs: pulses last one cycle, data_out holds the last payload byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            data_valid  <= dv_nx;
            frame_start <= fs_nx;
            sync_err    <= se_nx;
            if (dv_nx) begin
                data_out <= sreg_nx;
            end
        end
    end

endmodule
